// File: rtl/reg_writeback_unit_pkg.sv
// Shared writeback definitions: WB_SEL mux codes, load funct3 codes and the register index width.
package reg_writeback_unit_pkg;

   localparam int REG_IDX_W = 5;

   typedef enum logic [1:0] {
      WB_SEL_ALU  = 2'b00,
      WB_SEL_MEM  = 2'b01,
      WB_SEL_PC4  = 2'b10,
      WB_SEL_RSVD = 2'b11
   } wb_sel_e;

   typedef enum logic [2:0] {
      FUNCT3_LB  = 3'b000,
      FUNCT3_LH  = 3'b001,
      FUNCT3_LW  = 3'b010,
      FUNCT3_LBU = 3'b100,
      FUNCT3_LHU = 3'b101
   } funct3_e;

endpackage

// File: rtl/reg_writeback_unit_load_data_align.sv
// Load data alignment: picks the byte/half at the load offset from an aligned word and sign/zero-extends it.
module reg_writeback_unit_load_data_align
   import reg_writeback_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]            funct3,
   input  logic [1:0]            offset,
   input  logic [DATA_WIDTH-1:0] word,
   output logic [DATA_WIDTH-1:0] value
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      byte_sel = word[7:0];
      case (offset)
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         2'd3:    byte_sel = word[31:24];
         default: byte_sel = word[7:0];
      endcase
      half_sel = offset[1] ? word[31:16] : word[15:0];
   end

   // Unknown funct3 falls back to the full word.
   always_comb begin
      value = word;
      case (funct3)
         FUNCT3_LB:  value = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
         FUNCT3_LH:  value = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
         FUNCT3_LBU: value = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
         FUNCT3_LHU: value = {{(DATA_WIDTH-16){1'b0}}, half_sel};
         default:    value = word;
      endcase
   end

endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write driver: queues retiring results in a small FIFO, debug writes take port priority.
// Optional FORWARD_EN macro adds FWD_VALID/FWD_ADDRESS/FWD_DATA exposing the newest queued entry.
module reg_writeback_unit
   import reg_writeback_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = REG_IDX_W,
   parameter int DEPTH      = 2
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   input  logic                  IN_REG_WRITE,
   input  logic [ADDR_WIDTH-1:0] IN_RD_ADDR,
   input  logic [1:0]            IN_WB_SEL,
   input  logic [2:0]            IN_FUNCT3,
   input  logic [DATA_WIDTH-1:0] IN_ALU_RESULT,
   input  logic [DATA_WIDTH-1:0] IN_MEM_DATA,
   input  logic [DATA_WIDTH-1:0] IN_PC_PLUS4,
   input  logic                  DBG_WRITE_ENABLE,
   input  logic [ADDR_WIDTH-1:0] DBG_WRITE_ADDRESS,
   input  logic [DATA_WIDTH-1:0] DBG_WRITE_DATA,
   output logic                  WRITE_ENABLE,
   output logic [ADDR_WIDTH-1:0] WRITE_ADDRESS,
   output logic [DATA_WIDTH-1:0] WRITE_DATA,
   output logic                  PENDING
`ifdef FORWARD_EN
   ,
   output logic                  FWD_VALID,
   output logic [ADDR_WIDTH-1:0] FWD_ADDRESS,
   output logic [DATA_WIDTH-1:0] FWD_DATA
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [ADDR_WIDTH-1:0] fifo_addr [DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;

   logic [DATA_WIDTH-1:0] load_value;
   logic [DATA_WIDTH-1:0] wb_value;
   logic                  not_empty;
   logic                  accept;
   logic                  push;
   logic                  dbg_take;
   logic                  pop;

   reg_writeback_unit_load_data_align #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_load_data_align (
      .funct3(IN_FUNCT3),
      .offset(IN_ALU_RESULT[1:0]),
      .word  (IN_MEM_DATA),
      .value (load_value)
   );

   // Reserved select code behaves as the ALU path.
   always_comb begin
      wb_value = IN_ALU_RESULT;
      case (IN_WB_SEL)
         WB_SEL_MEM: wb_value = load_value;
         WB_SEL_PC4: wb_value = IN_PC_PLUS4;
         default:    wb_value = IN_ALU_RESULT;
      endcase
   end

   assign not_empty = (count != '0);
   assign IN_READY  = !RESET && (count < FULL);
   assign accept    = IN_VALID && IN_READY;
   assign push      = accept && IN_REG_WRITE && (IN_RD_ADDR != '0);
   assign dbg_take  = DBG_WRITE_ENABLE && (DBG_WRITE_ADDRESS != '0);
   assign pop       = !dbg_take && not_empty;
   assign PENDING   = not_empty;

   // A debug write to x0 never claims the port, so the queue drains underneath it.
   always_comb begin
      WRITE_ENABLE  = 1'b0;
      WRITE_ADDRESS = '0;
      WRITE_DATA    = '0;
      if (!RESET) begin
         if (dbg_take) begin
            WRITE_ENABLE  = 1'b1;
            WRITE_ADDRESS = DBG_WRITE_ADDRESS;
            WRITE_DATA    = DBG_WRITE_DATA;
         end else if (not_empty) begin
            WRITE_ENABLE  = 1'b1;
            WRITE_ADDRESS = fifo_addr[rd_ptr];
            WRITE_DATA    = fifo_data[rd_ptr];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; count gates every read, so stale contents are never observed.
   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_addr[wr_ptr] <= IN_RD_ADDR;
         fifo_data[wr_ptr] <= wb_value;
      end
   end

`ifdef FORWARD_EN
   logic [PTR_W-1:0] newest;
   assign newest      = wr_ptr - 1'b1;
   assign FWD_VALID   = not_empty;
   assign FWD_ADDRESS = not_empty ? fifo_addr[newest] : '0;
   assign FWD_DATA    = not_empty ? fifo_data[newest] : '0;
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit with a behavioural reg_file capturing the write port.
module tb_reg_writeback_unit;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        IN_VALID;
   logic        IN_READY;
   logic        IN_REG_WRITE;
   logic [4:0]  IN_RD_ADDR;
   logic [1:0]  IN_WB_SEL;
   logic [2:0]  IN_FUNCT3;
   logic [31:0] IN_ALU_RESULT;
   logic [31:0] IN_MEM_DATA;
   logic [31:0] IN_PC_PLUS4;
   logic        DBG_WRITE_ENABLE;
   logic [4:0]  DBG_WRITE_ADDRESS;
   logic [31:0] DBG_WRITE_DATA;
   logic        WRITE_ENABLE;
   logic [4:0]  WRITE_ADDRESS;
   logic [31:0] WRITE_DATA;
   logic        PENDING;
`ifdef FORWARD_EN
   logic        FWD_VALID;
   logic [4:0]  FWD_ADDRESS;
   logic [31:0] FWD_DATA;
`endif

   int checks = 0;
   int errors = 0;
   int n_before;

   logic [31:0] rf [32] = '{default: '0};
   logic [4:0]  wr_log [$];

   always #5 CLK = ~CLK;

   reg_writeback_unit #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(5),
      .DEPTH(2)
   ) dut (
      .CLK              (CLK),
      .RESET            (RESET),
      .IN_VALID         (IN_VALID),
      .IN_READY         (IN_READY),
      .IN_REG_WRITE     (IN_REG_WRITE),
      .IN_RD_ADDR       (IN_RD_ADDR),
      .IN_WB_SEL        (IN_WB_SEL),
      .IN_FUNCT3        (IN_FUNCT3),
      .IN_ALU_RESULT    (IN_ALU_RESULT),
      .IN_MEM_DATA      (IN_MEM_DATA),
      .IN_PC_PLUS4      (IN_PC_PLUS4),
      .DBG_WRITE_ENABLE (DBG_WRITE_ENABLE),
      .DBG_WRITE_ADDRESS(DBG_WRITE_ADDRESS),
      .DBG_WRITE_DATA   (DBG_WRITE_DATA),
      .WRITE_ENABLE     (WRITE_ENABLE),
      .WRITE_ADDRESS    (WRITE_ADDRESS),
      .WRITE_DATA       (WRITE_DATA),
      .PENDING          (PENDING)
`ifdef FORWARD_EN
      ,
      .FWD_VALID        (FWD_VALID),
      .FWD_ADDRESS      (FWD_ADDRESS),
      .FWD_DATA         (FWD_DATA)
`endif
   );

   // Behavioural reg_file: commits whatever the write port presents at each rising edge.
   always @(posedge CLK) begin
      if (WRITE_ENABLE === 1'b1) begin
         rf[WRITE_ADDRESS] <= WRITE_DATA;
         wr_log.push_back(WRITE_ADDRESS);
      end
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Presents one retiring instruction for exactly one accepting edge; returns at the following negedge.
   task automatic push(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4);
      @(negedge CLK);
      IN_VALID      = 1'b1;
      IN_REG_WRITE  = 1'b1;
      IN_RD_ADDR    = rd;
      IN_WB_SEL     = sel;
      IN_FUNCT3     = f3;
      IN_ALU_RESULT = alu;
      IN_MEM_DATA   = mem;
      IN_PC_PLUS4   = pc4;
      @(posedge CLK);
      @(negedge CLK);
      IN_VALID = 1'b0;
   endtask

   initial begin
      IN_VALID          = 1'b0;
      IN_REG_WRITE      = 1'b0;
      IN_RD_ADDR        = '0;
      IN_WB_SEL         = '0;
      IN_FUNCT3         = '0;
      IN_ALU_RESULT     = '0;
      IN_MEM_DATA       = '0;
      IN_PC_PLUS4       = '0;
      DBG_WRITE_ENABLE  = 1'b1;
      DBG_WRITE_ADDRESS = 5'd7;
      DBG_WRITE_DATA    = 32'h77;

      // Reset state, including a debug request that must be masked.
      #2;
      check("rst_in_ready", 32'(IN_READY), 32'd0);
      check("rst_we", 32'(WRITE_ENABLE), 32'd0);
      check("rst_addr", 32'(WRITE_ADDRESS), 32'd0);
      check("rst_data", WRITE_DATA, 32'd0);
      check("rst_pending", 32'(PENDING), 32'd0);
`ifdef FORWARD_EN
      check("rst_fwd_valid", 32'(FWD_VALID), 32'd0);
`endif
      DBG_WRITE_ENABLE = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      check("ready_after_rst", 32'(IN_READY), 32'd1);

      // ALU write with single-cycle latency.
      push(5'd1, 2'b00, 3'd0, 32'd10, 32'd0, 32'd0);
      check("alu_we", 32'(WRITE_ENABLE), 32'd1);
      check("alu_addr", 32'(WRITE_ADDRESS), 32'd1);
      check("alu_data", WRITE_DATA, 32'd10);
      check("alu_pending", 32'(PENDING), 32'd1);
      @(negedge CLK);
      check("alu_we_idle", 32'(WRITE_ENABLE), 32'd0);
      check("alu_pending_idle", 32'(PENDING), 32'd0);
      check("alu_r1", rf[1], 32'd10);

      // x0 destination and REG_WRITE=0 are consumed without queueing.
      @(negedge CLK);
      IN_VALID = 1'b1; IN_REG_WRITE = 1'b1; IN_RD_ADDR = 5'd0; IN_WB_SEL = 2'b00; IN_ALU_RESULT = 32'd10;
      #1;
      check("x0_ready", 32'(IN_READY), 32'd1);
      @(posedge CLK);
      @(negedge CLK);
      IN_VALID = 1'b1; IN_REG_WRITE = 1'b0; IN_RD_ADDR = 5'd6;
      check("x0_we", 32'(WRITE_ENABLE), 32'd0);
      check("x0_pending", 32'(PENDING), 32'd0);
      check("x0_ready_after", 32'(IN_READY), 32'd1);
      @(posedge CLK);
      @(negedge CLK);
      IN_VALID = 1'b0; IN_REG_WRITE = 1'b1;
      check("nowr_we", 32'(WRITE_ENABLE), 32'd0);
      check("nowr_pending", 32'(PENDING), 32'd0);
      check("r0_zero", rf[0], 32'd0);
      check("r6_untouched", rf[6], 32'd0);

      // Load extraction from 0x8081_F2A5.
      push(5'd3, 2'b01, 3'b000, 32'h1, 32'h8081_F2A5, 32'd0);
      check("lb_off1", WRITE_DATA, 32'hFFFF_FFF2);
      push(5'd3, 2'b01, 3'b100, 32'h1, 32'h8081_F2A5, 32'd0);
      check("lbu_off1", WRITE_DATA, 32'h0000_00F2);
      push(5'd3, 2'b01, 3'b001, 32'h2, 32'h8081_F2A5, 32'd0);
      check("lh_off2", WRITE_DATA, 32'hFFFF_8081);
      push(5'd3, 2'b01, 3'b101, 32'h2, 32'h8081_F2A5, 32'd0);
      check("lhu_off2", WRITE_DATA, 32'h0000_8081);
      push(5'd3, 2'b01, 3'b010, 32'h0, 32'h8081_F2A5, 32'd0);
      check("lw", WRITE_DATA, 32'h8081_F2A5);
      push(5'd3, 2'b01, 3'b000, 32'h0, 32'h8081_F2A5, 32'd0);
      check("lb_off0", WRITE_DATA, 32'hFFFF_FFA5);
      push(5'd3, 2'b01, 3'b100, 32'h3, 32'h8081_F2A5, 32'd0);
      check("lbu_off3", WRITE_DATA, 32'h0000_0080);
      push(5'd3, 2'b01, 3'b011, 32'h1, 32'h8081_F2A5, 32'd0);
      check("undef_f3_word", WRITE_DATA, 32'h8081_F2A5);
      push(5'd3, 2'b11, 3'b000, 32'h1234_5678, 32'h8081_F2A5, 32'd0);
      check("rsvd_sel_alu", WRITE_DATA, 32'h1234_5678);

      // Link value.
      push(5'd1, 2'b10, 3'd0, 32'd0, 32'd0, 32'h104);
      check("link_addr", 32'(WRITE_ADDRESS), 32'd1);
      check("link_data", WRITE_DATA, 32'h104);
`ifdef FORWARD_EN
      check("fwd_valid", 32'(FWD_VALID), 32'd1);
      check("fwd_addr", 32'(FWD_ADDRESS), 32'd1);
      check("fwd_data", FWD_DATA, 32'h104);
`endif
      @(negedge CLK);
      check("link_r1", rf[1], 32'h104);
`ifdef FORWARD_EN
      check("fwd_valid_empty", 32'(FWD_VALID), 32'd0);
`endif

      // Debug priority: R5 held for three cycles while rd=2,3,4 retire.
      @(negedge CLK);
      wr_log.delete();
      DBG_WRITE_ENABLE = 1'b1; DBG_WRITE_ADDRESS = 5'd5; DBG_WRITE_DATA = 32'h55;
      IN_VALID = 1'b1; IN_REG_WRITE = 1'b1; IN_WB_SEL = 2'b00; IN_RD_ADDR = 5'd2; IN_ALU_RESULT = 32'h22;
      #1;
      check("dbg_c0_addr", 32'(WRITE_ADDRESS), 32'd5);
      check("dbg_c0_data", WRITE_DATA, 32'h55);
      @(negedge CLK);
      IN_RD_ADDR = 5'd3; IN_ALU_RESULT = 32'h33;
      #1;
      check("dbg_c1_ready", 32'(IN_READY), 32'd1);
      check("dbg_c1_addr", 32'(WRITE_ADDRESS), 32'd5);
      @(negedge CLK);
      IN_RD_ADDR = 5'd4; IN_ALU_RESULT = 32'h44;
      #1;
      check("dbg_c2_ready_full", 32'(IN_READY), 32'd0);
      check("dbg_c2_addr", 32'(WRITE_ADDRESS), 32'd5);
      @(negedge CLK);
      DBG_WRITE_ENABLE = 1'b0;
      #1;
      check("drain_r2_addr", 32'(WRITE_ADDRESS), 32'd2);
      check("drain_r2_data", WRITE_DATA, 32'h22);
      check("full_no_bypass", 32'(IN_READY), 32'd0);
      @(negedge CLK);
      check("drain_r3_addr", 32'(WRITE_ADDRESS), 32'd3);
      check("drain_ready", 32'(IN_READY), 32'd1);
      @(negedge CLK);
      IN_VALID = 1'b0;
      check("drain_r4_addr", 32'(WRITE_ADDRESS), 32'd4);
      check("drain_r4_data", WRITE_DATA, 32'h44);
      @(negedge CLK);
      check("drain_done", 32'(PENDING), 32'd0);
      check("dbg_log_len", 32'(wr_log.size()), 32'd6);
      check("dbg_log_first", 32'(wr_log[0]), 32'd5);
      check("dbg_log_r2", 32'(wr_log[3]), 32'd2);
      check("dbg_log_r3", 32'(wr_log[4]), 32'd3);
      check("dbg_log_r4", 32'(wr_log[5]), 32'd4);
      check("dbg_r5", rf[5], 32'h55);
      check("dbg_r4", rf[4], 32'h44);

      // Debug write to x0 lets the queue drain.
      push(5'd7, 2'b00, 3'd0, 32'h77, 32'd0, 32'd0);
      DBG_WRITE_ENABLE = 1'b1; DBG_WRITE_ADDRESS = 5'd0; DBG_WRITE_DATA = 32'hDEAD;
      #1;
      check("dbg_x0_addr", 32'(WRITE_ADDRESS), 32'd7);
      check("dbg_x0_data", WRITE_DATA, 32'h77);
      @(negedge CLK);
      DBG_WRITE_ENABLE = 1'b0;
      check("dbg_x0_drained", 32'(PENDING), 32'd0);
      check("dbg_x0_r7", rf[7], 32'h77);
      check("dbg_x0_r0", rf[0], 32'd0);

      // Same rd: debug commits first, queued value lands last.
      push(5'd9, 2'b00, 3'd0, 32'h99, 32'd0, 32'd0);
      DBG_WRITE_ENABLE = 1'b1; DBG_WRITE_ADDRESS = 5'd9; DBG_WRITE_DATA = 32'hD9;
      #1;
      check("same_rd_dbg", WRITE_DATA, 32'hD9);
      @(negedge CLK);
      DBG_WRITE_ENABLE = 1'b0;
      #1;
      check("same_rd_queued", WRITE_DATA, 32'h99);
      @(negedge CLK);
      check("same_rd_r9", rf[9], 32'h99);

      // Reset with two entries queued behind a debug write.
      @(negedge CLK);
      DBG_WRITE_ENABLE = 1'b1; DBG_WRITE_ADDRESS = 5'd5; DBG_WRITE_DATA = 32'h55;
      IN_VALID = 1'b1; IN_RD_ADDR = 5'd10; IN_ALU_RESULT = 32'hA;
      @(negedge CLK);
      IN_RD_ADDR = 5'd11; IN_ALU_RESULT = 32'hB;
      @(negedge CLK);
      IN_VALID = 1'b0;
      check("pre_rst_pending", 32'(PENDING), 32'd1);
      check("pre_rst_full", 32'(IN_READY), 32'd0);
      n_before = wr_log.size();
      #1;
      RESET = 1'b1;
      DBG_WRITE_ENABLE = 1'b0;
      #1;
      check("mid_rst_we", 32'(WRITE_ENABLE), 32'd0);
      check("mid_rst_pending", 32'(PENDING), 32'd0);
      check("mid_rst_ready", 32'(IN_READY), 32'd0);
      #4;
      RESET = 1'b0;
      repeat (4) @(negedge CLK);
      check("post_rst_no_write", 32'(wr_log.size()), 32'(n_before));
      check("post_rst_r10", rf[10], 32'd0);
      check("post_rst_r11", rf[11], 32'd0);
      check("post_rst_pending", 32'(PENDING), 32'd0);
      check("post_rst_ready", 32'(IN_READY), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
